// File: rtl/denorm_pkg.sv
// Shared constants for the normalizer/denormalizer pair: channel count, FSM states
// and the per-channel mean/std tables that both ends must agree on.
package denorm_pkg;

  localparam int N_CH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CALC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic signed [15:0] MEAN [0:N_CH-1] = '{
    16'sh0305, -16'sh0058, 16'sh0101, 16'sh013E,
    16'sh0144,  16'sh014E, 16'sh0154, 16'sh0133
  };

  // Std values are unsigned magnitudes; the MAC zero-extends them before multiplying.
  localparam logic [15:0] STD [0:N_CH-1] = '{
    16'h01F1, 16'h00FD, 16'h0110, 16'h0013,
    16'h002D, 16'h002B, 16'h0024, 16'h0029
  };

endpackage

// File: rtl/denorm_mac.sv
// Combinational x = round(norm * std) + mean for one channel.
// DENORM_SAT_EN selects saturation to the 16-bit signed range; otherwise the sum wraps.
module denorm_mac
  import denorm_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] norm,
  input  logic [W-1:0] std_val,
  input  logic [W-1:0] mean,
  output logic [W-1:0] result
);

  localparam logic signed [2*W:0] HALF_LSB = (2*W+1)'(128);

  logic signed [2*W:0]   prod;
  logic signed [2*W:0]   rnd;
  logic signed [2*W+1:0] sum;

  assign prod = $signed({{(W+1){norm[W-1]}}, norm}) * $signed({{(W+1){1'b0}}, std_val});
  // Adding half an LSB before the arithmetic shift rounds ties toward +inf.
  assign rnd  = (prod + HALF_LSB) >>> 8;
  assign sum  = $signed({rnd[2*W], rnd}) + $signed({{(W+2){mean[W-1]}}, mean});

`ifdef DENORM_SAT_EN
  logic fits;
  assign fits = (sum[2*W+1:W-1] == '0) || (sum[2*W+1:W-1] == '1);

  always_comb begin
    result = sum[W-1:0];
    if (!fits) begin
      result = sum[2*W+1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  logic unused_sum_hi;
  assign unused_sum_hi = ^sum[2*W+1:W];
  assign result        = sum[W-1:0];
`endif

endmodule

// File: rtl/denormalizer.sv
// Eight-channel Q8.8 -> raw sensor denormalizer: one shared MAC stepped across the
// channels by a small FSM. Overflow handling is set by DENORM_SAT_EN in denorm_mac.
module denormalizer #(
  parameter int N_CH = 8,
  parameter int W    = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [W-1:0] i_norm [0:N_CH-1],
  output logic [W-1:0] o_data [0:N_CH-1],
  output logic         o_busy,
  output logic         o_finished
);

  import denorm_pkg::*;

  localparam int CW = $clog2(N_CH);

  state_t        state_reg;
  state_t        state_next;
  logic [CW-1:0] cnt_reg;
  logic [W-1:0]  norm_buf [0:N_CH-1];
  logic [W-1:0]  res_buf  [0:N_CH-1];
  logic [W-1:0]  mac_out;
  logic          last_ch;

  assign last_ch = (cnt_reg == CW'(N_CH - 1));
  assign o_busy  = (state_reg != S_IDLE);

  denorm_mac #(
    .W(W)
  ) u_mac (
    .norm    (norm_buf[cnt_reg]),
    .std_val (STD[cnt_reg]),
    .mean    (MEAN[cnt_reg]),
    .result  (mac_out)
  );

  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (i_start) state_next = S_LOAD;
      S_LOAD:  state_next = S_CALC;
      S_CALC:  if (last_ch) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      cnt_reg    <= '0;
      o_finished <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        norm_buf[i] <= '0;
        res_buf[i]  <= '0;
        o_data[i]   <= '0;
      end
    end else begin
      o_finished <= 1'b0;
      case (state_reg)
        S_LOAD: begin
          cnt_reg <= '0;
          for (int i = 0; i < N_CH; i++) begin
            norm_buf[i] <= i_norm[i];
          end
        end
        S_CALC: begin
          cnt_reg          <= cnt_reg + CW'(1);
          res_buf[cnt_reg] <= mac_out;
          // The last channel is still on the MAC output, so publish it directly.
          if (last_ch) begin
            o_finished <= 1'b1;
            for (int i = 0; i < N_CH; i++) begin
              o_data[i] <= (CW'(i) == cnt_reg) ? mac_out : res_buf[i];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_denormalizer.sv
// Self-checking bench for denormalizer: directed and random runs against an
// arithmetic reference of round(norm * std) + mean.
module tb_denormalizer;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_start;
  logic [15:0] i_norm [0:7];
  logic [15:0] o_data [0:7];
  logic        o_busy;
  logic        o_finished;

  int checks = 0;
  int errors = 0;

  localparam int MEAN_T [8] = '{773, -88, 257, 318, 324, 334, 340, 307};
  localparam int STD_T  [8] = '{497, 253, 272, 19, 45, 43, 36, 41};

  logic [15:0] stim [8];

  denormalizer dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_norm     (i_norm),
    .o_data     (o_data),
    .o_busy     (o_busy),
    .o_finished (o_finished)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [15:0] ref_ch(input int ch, input logic [15:0] n);
    longint p;
    longint s;
    p = longint'($signed(n)) * longint'(STD_T[ch]);
    p = (p + 128) >>> 8;
    s = p + longint'(MEAN_T[ch]);
`ifdef DENORM_SAT_EN
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`endif
    return s[15:0];
  endfunction

  // Drives stim with a one-cycle start, then counts edges until o_finished (-1 on timeout).
  task automatic do_run(output int lat);
    @(negedge i_clk);
    for (int i = 0; i < 8; i++) i_norm[i] = stim[i];
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge i_clk);
      if (o_finished) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    i_rst_n = 1'b1;
    i_start = 1'b0;
    for (int i = 0; i < 8; i++) i_norm[i] = '0;
    repeat (3) @(negedge i_clk);
    checks++;
    if (o_busy !== 1'b0 || o_finished !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl busy=%b fin=%b required 0 0", o_busy, o_finished);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (o_data[i] !== 16'h0000) begin
        errors++;
        $display("FAIL reset_data[%0d] got %h required 0000", i, o_data[i]);
      end
    end
    i_rst_n = 1'b0;
    @(negedge i_clk);
    $display("reset: done");
  endtask

  task automatic test_zero;
    logic [15:0] exp_z [8];
    int lat;
    exp_z = '{16'h0305, 16'hFFA8, 16'h0101, 16'h013E, 16'h0144, 16'h014E, 16'h0154, 16'h0133};
    for (int i = 0; i < 8; i++) stim[i] = '0;
    do_run(lat);
    checks++;
    if (lat !== 9 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_latency got %0d busy=%b required 9 busy=1", lat, o_busy);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (o_data[i] !== exp_z[i]) begin
        errors++;
        $display("FAIL zero_data[%0d] got %h required %h", i, o_data[i], exp_z[i]);
      end
    end
    @(negedge i_clk);
    checks++;
    if (o_finished !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_pulse_end fin=%b busy=%b required 0 0", o_finished, o_busy);
    end
    $display("zero: latency %0d", lat);
  endtask

  task automatic test_directed;
    logic [15:0] v0 [6];
    logic [15:0] v3 [6];
    int lat;
    v0 = '{16'h0100, 16'h0000, 16'h0000, 16'h7FFF, 16'h8000, 16'h0001};
    v3 = '{16'hFF00, 16'h0080, 16'hFF80, 16'h0000, 16'h7FFF, 16'h8000};
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 8; i++) stim[i] = '0;
      stim[0] = v0[t];
      stim[3] = v3[t];
      do_run(lat);
      checks++;
      if (lat !== 9) begin
        errors++;
        $display("FAIL dir%0d_latency got %0d required 9", t, lat);
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (o_data[i] !== ref_ch(i, stim[i])) begin
          errors++;
          $display("FAIL dir%0d_data[%0d] got %h required %h", t, i, o_data[i], ref_ch(i, stim[i]));
        end
      end
      $display("directed %0d: ch0 %h -> %h, ch3 %h -> %h", t, v0[t], o_data[0], v3[t], o_data[3]);
    end
    // Literal spot values, independent of the reference function.
    stim[0] = 16'h0100; stim[3] = 16'hFF00;
    for (int i = 1; i < 8; i++) if (i != 3) stim[i] = '0;
    do_run(lat);
    checks++;
    if (o_data[0] !== 16'h04F6 || o_data[3] !== 16'h012B) begin
      errors++;
      $display("FAIL spot_values got %h %h required 04f6 012b", o_data[0], o_data[3]);
    end
  endtask

  task automatic test_random;
    int lat;
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 8; i++) stim[i] = 16'($urandom);
      do_run(lat);
      checks++;
      if (lat !== 9) begin
        errors++;
        $display("FAIL rand%0d_latency got %0d required 9", t, lat);
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (o_data[i] !== ref_ch(i, stim[i])) begin
          errors++;
          $display("FAIL rand%0d_data[%0d] norm %h got %h required %h", t, i, stim[i], o_data[i], ref_ch(i, stim[i]));
        end
      end
      $display("random %0d: latency %0d", t, lat);
    end
  endtask

  task automatic test_ignore_start;
    logic [15:0] a [8];
    logic [15:0] cap [8];
    int pulses;
    for (int i = 0; i < 8; i++) a[i] = 16'($urandom);
    @(negedge i_clk);
    for (int i = 0; i < 8; i++) i_norm[i] = a[i];
    i_start = 1'b1;
    @(negedge i_clk);                 // after edge 0
    i_start = 1'b0;
    @(negedge i_clk);                 // after edge 1
    @(negedge i_clk);                 // after edge 2
    for (int i = 0; i < 8; i++) i_norm[i] = ~a[i];
    @(negedge i_clk);                 // after edge 3
    i_start = 1'b1;
    @(negedge i_clk);                 // after edge 4
    i_start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) cap[i] = '0;
    for (int k = 0; k < 25; k++) begin
      @(negedge i_clk);
      if (o_finished) begin
        pulses++;
        for (int i = 0; i < 8; i++) cap[i] = o_data[i];
      end
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL ignore_pulses got %0d required 1", pulses);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cap[i] !== ref_ch(i, a[i])) begin
        errors++;
        $display("FAIL ignore_data[%0d] got %h required %h", i, cap[i], ref_ch(i, a[i]));
      end
    end
    $display("ignore_start: pulses %0d", pulses);
  endtask

  task automatic test_reset_midrun;
    int pulses;
    @(negedge i_clk);
    for (int i = 0; i < 8; i++) i_norm[i] = 16'($urandom);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (4) @(negedge i_clk);      // after edge 4
    i_rst_n = 1'b1;
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_finished !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ctrl busy=%b fin=%b required 0 0", o_busy, o_finished);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (o_data[i] !== 16'h0000) begin
        errors++;
        $display("FAIL midrst_data[%0d] got %h required 0000", i, o_data[i]);
      end
    end
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b0;
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge i_clk);
      if (o_finished) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL midrst_pulses got %0d required 0", pulses);
    end
    $display("reset_midrun: pulses %0d", pulses);
  endtask

  task automatic test_back_to_back;
    logic [15:0] hist [0:49][8];
    int pulses;
    int prev_e;
    @(negedge i_clk);
    pulses = 0;
    prev_e = -1;
    for (int k = 0; k < 48; k++) begin
      if (k > 0 && o_finished) begin
        int e;
        e = k - 1;                    // this sample follows edge e
        pulses++;
        checks++;
        if ((e - 9) % 11 != 0 || (prev_e >= 0 && e - prev_e != 11)) begin
          errors++;
          $display("FAIL b2b_spacing pulse at edge %0d prev %0d required period 11 from edge 9", e, prev_e);
        end
        if (e >= 8) begin
          for (int i = 0; i < 8; i++) begin
            checks++;
            if (o_data[i] !== ref_ch(i, hist[e - 8][i])) begin
              errors++;
              $display("FAIL b2b_data[%0d] edge %0d got %h required %h", i, e, o_data[i], ref_ch(i, hist[e - 8][i]));
            end
          end
        end
        $display("back_to_back: pulse at edge %0d", e);
        prev_e = e;
      end
      for (int i = 0; i < 8; i++) begin
        hist[k][i] = 16'($urandom);
        i_norm[i]  = hist[k][i];
      end
      i_start = (k < 30);
      @(negedge i_clk);
    end
    i_start = 1'b0;
    checks++;
    if (pulses !== 3) begin
      errors++;
      $display("FAIL b2b_pulses got %0d required 3", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_midrun();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/denormalizer.md
# denormalizer

Inverse of the sensor normalizer. Takes eight signed Q8.8 fixed-point normalized values and reconstructs raw 16-bit signed sensor integers as `x = round(norm * std) + mean`, using per-channel constants. It sits on the classifier/replay side of the glove pipeline, where model-space values are mapped back to sensor space for debug readback and for loopback checking of the normalizer. The datapath is one shared multiply-add, stepped through the eight channels under a small FSM.

## Interface
Parameters:
- `N_CH`, 8: number of channels. It is fixed by the constant tables in the package.
- `W`, 16: data width of inputs and outputs.

Ports:
- `i_clk`, in, 1: clock.
- `i_rst_n`, in, 1: reset, asynchronous, active-high. The name is historical; the team's decided convention is active-high.
- `i_start`, in, 1: request a conversion. Sampled only in `S_IDLE`.
- `i_norm[0:7]`, in, 16 each: signed Q8.8 normalized values.
- `o_data[0:7]`, out, 16 each: signed integer reconstructed values.
- `o_busy`, out, 1: high whenever the state is not `S_IDLE`.
- `o_finished`, out, 1: one-cycle pulse; `o_data` is valid from this cycle onward.

## Operation
- FSM states and transitions:
  - `S_IDLE` goes to `S_LOAD` when `i_start` is high.
  - `S_LOAD` latches all of `i_norm` into a work buffer, clears the channel counter, then goes to `S_CALC`.
  - `S_CALC` processes channel `cnt` each cycle, for `cnt` = 0 to 7. At `cnt`==7 it goes to `S_DONE`.
  - `S_DONE` returns to `S_IDLE`.
- Per-channel arithmetic:
  - Product: `p = $signed(norm) * $signed({1'b0,std})`, 33-bit signed.
  - Rounding: `r = (p + 0x80) >>> 8`. This rounds half toward +inf.
  - Sum: `s = r + $signed(mean)`, computed at full width with no intermediate truncation.
  - `s` is then reduced to 16 bits according to the Configuration section.
- Results are collected in a result buffer. On the edge that enters `S_DONE`, all eight `o_data` registers update together and `o_finished` is set.
- `o_data` holds its value until the next run completes. It is never partially updated.
- `i_start` is ignored in `S_LOAD`, `S_CALC` and `S_DONE`; it is not queued.
- `i_norm` is sampled only at the `S_LOAD` edge. Changes to it afterwards do not affect the run in progress.

## Timing
- Reset values: state `S_IDLE`, `o_data` all 0x0000, `o_busy`=0, `o_finished`=0, counter and buffers 0.
- Let edge 0 be the clock edge that samples `i_start`=1 in `S_IDLE`.
  - Edge 1: load.
  - Edges 2 to 9: channels 0 to 7.
  - After edge 9: `o_finished`=1 and `o_data` is valid.
  - After edge 10: `o_finished`=0 and the state is `S_IDLE`.
- Total latency is 9 cycles from the sampling edge to `o_finished`. `o_finished` is exactly one cycle wide.
- `o_busy` rises after edge 0 and falls after edge 10.
- If `i_start` is held high, the next run is sampled at edge 11. The run period is 11 cycles.
- Reset asserted mid-run: all outputs return immediately to their reset values, and no `o_finished` pulse is emitted for the aborted run.

## Configuration
- Macro `DENORM_SAT_EN`.
- Defined: `s` saturates to [0x8000, 0x7FFF].
- Undefined: `s` wraps, taking the low 16 bits.

## Structure
- Package `denorm_pkg` holds:
  - `N_CH`;
  - state enum `S_IDLE`/`S_LOAD`/`S_CALC`/`S_DONE`;
  - `MEAN[0:7]` = {0x0305, -0x0058, 0x0101, 0x013E, 0x0144, 0x014E, 0x0154, 0x0133};
  - `STD[0:7]` = {0x01F1, 0x00FD, 0x0110, 0x0013, 0x002D, 0x002B, 0x0024, 0x0029}.
- The normalizer will also import these tables, so both ends share one source of truth.
- Sub-module `denorm_mac`: combinational multiply, round, add, and saturate-or-wrap.
  - Inputs: norm, std, mean.
  - Output: 16-bit value.
  - `DENORM_SAT_EN` is handled inside this sub-module.

## Test plan
- All `i_norm`=0x0000, start: `o_data`={0x0305, 0xFFA8, 0x0101, 0x013E, 0x0144, 0x014E, 0x0154, 0x0133}. `o_finished` occurs 9 cycles after the sampling edge and lasts 1 cycle.
- `i_norm[0]`=0x0100, `i_norm[3]`=0xFF00, others 0: `o_data[0]`=0x04F6, `o_data[3]`=0x012B.
- Rounding on channel 3:
  - 0x0080 gives `o_data[3]`=0x0148.
  - 0xFF80 gives `o_data[3]`=0x0135.
- Extremes on channel 0:
  - 0x7FFF gives 0x7FFF with `DENORM_SAT_EN`, or 0xFB83 without.
  - 0x8000 gives 0x8000 with `DENORM_SAT_EN`.
- Second `i_start` at edge 4, plus an `i_norm` change at edge 3: the change is ignored and exactly one `o_finished` pulse occurs. Separately, asserting `i_rst_n` at edge 5 gives `o_busy`=0, `o_data`=0 and no pulse.
- `i_start` held high for 30 cycles: `o_finished` pulses occur every 11 cycles, and each reflects the `i_norm` present at its own `S_LOAD` edge.
